cdc_bus_handshake_tx: RTL
=========================

Name: cdc_bus_handshake_tx

Overview:
- Source-domain (CLK) launcher for multi-bit CDC transfers using a 2-phase toggle handshake.
- Holds a data word stable on TX_DATA and toggles TX_REQ. Waits for the destination's toggled RX_ACK, which it synchronizes internally, before launching the next word.
- Pairs with the destination-side multi-flop synchronizer/capture logic; provides a one-entry pending buffer so the source can queue one word while a transfer is in flight.

Parameters:
BUS_WIDTH, 8, width of transferred data word
NUM_STAGES, 2, flip-flop stages in RX_ACK synchronizer (minimum 2)

Ports:
CLK  in  1  source-domain clock
RST  in  1  asynchronous, active-low reset
SRC_DATA  in  BUS_WIDTH  word offered by source logic
SRC_VALID  in  1  SRC_DATA valid; accepted when SRC_VALID & SRC_READY at a CLK rising edge
SRC_READY  out  1  pending buffer empty; combinational from registered pend_valid only (=!pend_valid)
TX_DATA  out  BUS_WIDTH  registered word presented to destination domain; stable while a transfer is outstanding
TX_REQ  out  1  registered request level; each toggle announces a new TX_DATA
RX_ACK  in  1  asynchronous ack level from destination; destination toggles it after capturing TX_DATA
BUSY  out  1  registered; 1 while a transfer is outstanding (state WAIT_ACK)
DONE  out  1  registered one-cycle pulse per completed transfer
PROTO_ERR  out  1  sticky; set on an ack toggle while IDLE; cleared only by RST

Behaviour:
- Reset (RST=0, async):
  - TX_DATA=0, TX_REQ=0, BUSY=0, DONE=0, PROTO_ERR=0.
  - State=IDLE, pend_valid=0, pend_data=0, all sync stages=0. Hence SRC_READY=1.
- ack_s: output of the NUM_STAGES-deep chain on RX_ACK. An RX_ACK change appears on ack_s after NUM_STAGES CLK edges.
- complete = (state==WAIT_ACK) && (ack_s==TX_REQ).
- IDLE:
  - On accept: TX_DATA<=SRC_DATA, TX_REQ<=~TX_REQ, BUSY<=1, go to WAIT_ACK. Launch is visible the cycle after the accept edge.
  - If ack_s!=TX_REQ in IDLE: PROTO_ERR<=1; no other effect.
- WAIT_ACK, no complete:
  - On accept: pend_data<=SRC_DATA, pend_valid<=1 (SRC_READY drops next cycle).
  - TX_DATA and TX_REQ are held.
- WAIT_ACK, complete (DONE<=1 for that edge only):
  - pend_valid=1: TX_DATA<=pend_data, TX_REQ<=~TX_REQ, pend_valid<=0. Stay in WAIT_ACK. SRC_READY=0 this cycle, so there is no accept.
  - pend_valid=0 and accept on the same edge: launch SRC_DATA directly (TX_DATA<=SRC_DATA, toggle TX_REQ). Stay in WAIT_ACK. pend_valid stays 0.
  - pend_valid=0 and no accept: go to IDLE, BUSY<=0.
- Throughput:
  - A transfer is outstanding from the launch edge until complete.
  - Minimum launch-to-DONE is NUM_STAGES + destination ack latency, plus 1 cycle.
  - Back-to-back launches occur on the completion edge with zero bubble.
- Ordering: words are launched in accept order. No word is dropped or duplicated.
- TX_DATA never changes except on the same edge as a TX_REQ toggle.
- Mid-operation reset: everything returns to reset values. In-flight and pending words are discarded. The destination side must be reset concurrently.

Decomposition:
- Shared package cdc_pkg holds:
  - State encoding localparams: IDLE=1'b0, WAIT_ACK=1'b1.
  - Constant MIN_SYNC_STAGES=2, used in a parameter-legality check.
- Sub-module bit_sync_chain (params NUM_STAGES; ports CLK, RST, D, Q): 1-bit reset-to-0 flop chain used for RX_ACK.
- FSM, pending buffer and output registers live in cdc_bus_handshake_tx.

Test Plan:
- Reset: RST=0 with random inputs -> TX_DATA=0, TX_REQ=0, BUSY=0, DONE=0, SRC_READY=1, PROTO_ERR=0.
- Single transfer: accept 8'hA5 in IDLE -> next cycle TX_DATA=A5, TX_REQ=1, BUSY=1. Model toggles RX_ACK=1 -> DONE pulses exactly NUM_STAGES+1 edges later, then BUSY=0.
- Queued word: accept 8'h11, then 8'h22 while WAIT_ACK -> SRC_READY=0. After ack of 11: DONE=1 and TX_DATA=22 with TX_REQ back to 0 on the same edge. After second ack, IDLE.
- Simultaneous complete + accept with empty buffer: offer 8'h3C on the completion edge -> TX_DATA=3C and TX_REQ toggles that edge, BUSY stays 1, pend_valid stays 0.
- Spurious ack: toggle RX_ACK while IDLE -> PROTO_ERR=1 after NUM_STAGES+1 edges and stays 1 until RST.
- Reset mid-transfer: assert RST while WAIT_ACK with a pending word -> all outputs at reset values. Next accepted word 8'h5A launches with TX_REQ 0->1.

Source files
------------

// File: rtl/cdc_bus_handshake_tx_pkg.sv
// cdc_pkg: types and constants shared by the CDC handshake launcher.
//   state_t         : launcher FSM encoding (IDLE=0, WAIT_ACK=1)
//   MIN_SYNC_STAGES : smallest synchronizer depth allowed for RX_ACK
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_bus_handshake_tx_sync.sv
// bit_sync_chain: 1-bit multi-flop synchronizer, every stage resets to 0.
//   CLK : destination clock of the chain
//   RST : asynchronous, active-low reset
//   D   : asynchronous input level
//   Q   : synchronized level, NUM_STAGES CLK edges after D changes
module bit_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [NUM_STAGES-1:0] sff;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sff <= '0;
    end else begin
      sff <= {sff[NUM_STAGES-2:0], D};
    end
  end

  assign Q = sff[NUM_STAGES-1];

endmodule

// File: rtl/cdc_bus_handshake_tx.sv
// cdc_bus_handshake_tx: source-side launcher for a 2-phase toggle handshake.
// A word is held on TX_DATA and announced by toggling TX_REQ; the next word
// is launched only once the synchronized RX_ACK matches TX_REQ again. A
// one-entry pending buffer lets the source queue a word during a transfer.
//
// Ports:
//   CLK, RST   : source clock, asynchronous active-low reset
//   SRC_DATA   : word offered by source logic
//   SRC_VALID  : SRC_DATA valid, accepted when SRC_READY is also high
//   SRC_READY  : pending buffer empty
//   TX_DATA    : registered word seen by the destination domain
//   TX_REQ     : registered request level, toggles once per launched word
//   RX_ACK     : asynchronous ack level from the destination
//   BUSY       : a transfer is outstanding
//   DONE       : one-cycle pulse per completed transfer
//   PROTO_ERR  : sticky, ack toggled while nothing was outstanding
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE     | nothing outstanding; ack_s must equal TX_REQ
// WAIT_ACK | TX_DATA launched, waiting for ack_s to match TX_REQ
module cdc_bus_handshake_tx
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] SRC_DATA,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 RX_ACK,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PROTO_ERR
);

  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("NUM_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  state_t               state;
  logic                 pend_valid;
  logic [BUS_WIDTH-1:0] pend_data;
  logic                 ack_s;
  logic                 accept;
  logic                 complete;

  bit_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (RX_ACK),
    .Q  (ack_s)
  );

  assign SRC_READY = !pend_valid;
  assign accept    = SRC_VALID && SRC_READY;
  // 2-phase: the transfer is acknowledged once the ack level catches up
  // with the request level.
  assign complete  = (state == WAIT_ACK) && (ack_s == TX_REQ);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      TX_DATA    <= '0;
      TX_REQ     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PROTO_ERR  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (ack_s != TX_REQ) begin
            PROTO_ERR <= 1'b1;
          end
          if (accept) begin
            TX_DATA <= SRC_DATA;
            TX_REQ  <= ~TX_REQ;
            BUSY    <= 1'b1;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (complete) begin
            DONE <= 1'b1;
            if (pend_valid) begin
              // Queued word goes out on the completion edge; SRC_READY is
              // low this cycle so no new accept can collide with it.
              TX_DATA    <= pend_data;
              TX_REQ     <= ~TX_REQ;
              pend_valid <= 1'b0;
            end else if (accept) begin
              // Bypass the empty buffer for a zero-bubble launch.
              TX_DATA <= SRC_DATA;
              TX_REQ  <= ~TX_REQ;
            end else begin
              BUSY  <= 1'b0;
              state <= IDLE;
            end
          end else if (accept) begin
            pend_data  <= SRC_DATA;
            pend_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
